brt_usb_20_rx_bit_decoder: RTL

//  Sits directly downstream of the serial-interface clock recovery, in the recovered-clock domain.

---
 rtl/brt_usb_20_rx_bit_decoder.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/brt_usb_20_rx_bit_decoder.sv
// ---------------------------------------------------------------------------
// brt_usb_20_rx_bit_decoder
//
// USB 2.0 receive bit-level decoder in the recovered-clock domain. One line
// sample arrives per bit_en strobe. The block decodes NRZI, strips stuffed
// bits, detects SYNC and EOP, and assembles LSB-first bytes. Its output is a
// byte stream with packet framing and error flags for the packet layer.
// It supports LS, FS and HS.
//
// Ports
//   clk        in  1  recovered bit-domain clock
//   rst_n      in  1  synchronous active-low reset
//   rx_en      in  1  receiver enable; low forces IDLE next cycle, no pkt_end
//   speed      in  2  0 LS, 1 FS, 2 HS (3 treated as FS); sampled in IDLE
//   bit_en     in  1  strobe: line_dp/line_dm hold a new bit sample
//   line_dp    in  1  sampled D+
//   line_dm    in  1  sampled D-
//   byte_data  out 8  assembled byte, valid with byte_valid
//   byte_valid out 1  one-cycle pulse per byte
//   pkt_start  out 1  one-cycle pulse when SYNC is accepted
//   pkt_end    out 1  one-cycle pulse on EOP or abort
//   pkt_err    out 1  qualifies pkt_end; 1 = packet bad
//   err_code   out 2  0 none, 1 stuff, 2 alignment/squelch, 3 SE0 in SYNC
//   rx_active  out 1  high from pkt_start through pkt_end inclusive
// ---------------------------------------------------------------------------
module brt_usb_20_rx_bit_decoder #(
  parameter int unsigned MIN_SYNC_ZEROS = 3,
  parameter int unsigned STUFF_LEN      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_en,
  input  logic [1:0] speed,
  input  logic       bit_en,
  input  logic       line_dp,
  input  logic       line_dm,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       rx_active
);

  localparam logic [4:0] MIN_ZEROS_C = 5'(MIN_SYNC_ZEROS);
  localparam logic [2:0] STUFF_LEN_C = 3'(STUFF_LEN);
  localparam logic [4:0] ZERO_MAX_C  = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC      = 3'd1,
    ST_DATA      = 3'd2,
    ST_EOP       = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] speed_q, speed_d;
  logic       prev_q, prev_d;          // previous J/K line state, 1 = J
  logic       prev_nxt_s;
  logic [4:0] zero_cnt_q, zero_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic [7:0] sreg_q, sreg_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic       pkt_start_q, pkt_start_d;
  logic       pkt_end_q, pkt_end_d;
  logic       pkt_err_q, pkt_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       rx_active_q, rx_active_d;

  logic [1:0] cur_speed_s;
  logic       is_ls_s, is_hs_s;
  logic       line_se0_s, line_j_s, dec_s;
  logic [7:0] sreg_shift_s;

  // Line-state and NRZI decode of the current sample
  always_comb begin
    // Speed is live while idle so the first K is decoded with the new speed.
    cur_speed_s  = (state_q == ST_IDLE) ? speed : speed_q;
    is_ls_s      = (cur_speed_s == 2'd0);
    is_hs_s      = (cur_speed_s == 2'd2);
    // {1,1} is illegal on the bus and is folded into SE0.
    line_se0_s   = (line_dp == line_dm);
    line_j_s     = !line_se0_s && (is_ls_s ? (!line_dp && line_dm) : (line_dp && !line_dm));
    dec_s        = (line_j_s == prev_q);
    sreg_shift_s = {dec_s, sreg_q[7:1]};
  end

  // Next-state logic for the decoder FSM and all registered outputs
  always_comb begin
    state_d      = state_q;
    speed_d      = (state_q == ST_IDLE) ? speed : speed_q;
    prev_nxt_s   = prev_q;
    zero_cnt_d   = zero_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    sreg_d       = sreg_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    pkt_start_d  = 1'b0;
    pkt_end_d    = 1'b0;
    pkt_err_d    = 1'b0;
    err_code_d   = err_code_q;

    if (!rx_en) begin
      state_d = ST_IDLE;
    end else if (bit_en) begin
      case (state_q)
        ST_IDLE: begin
          if (!line_se0_s && !line_j_s) begin
            // First K against the preset J is the first SYNC zero.
            state_d    = ST_SYNC;
            zero_cnt_d = 5'd1;
            prev_nxt_s = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_SYNC: begin
          if (line_se0_s) begin
            if (is_hs_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d    = ST_WAIT_IDLE;
              err_code_d = 2'd3;
            end
          end else if (!dec_s) begin
            prev_nxt_s = line_j_s;
            zero_cnt_d = (zero_cnt_q == ZERO_MAX_C) ? zero_cnt_q : (zero_cnt_q + 5'd1);
          end else if (zero_cnt_q >= MIN_ZEROS_C) begin
            state_d     = ST_DATA;
            pkt_start_d = 1'b1;
            err_code_d  = 2'd0;
            bit_cnt_d   = 3'd0;
            ones_cnt_d  = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_DATA: begin
          if (line_se0_s) begin
            if (is_hs_s) begin
              // Squelch in the middle of an HS packet: abort.
              state_d    = ST_IDLE;
              pkt_end_d  = 1'b1;
              pkt_err_d  = 1'b1;
              err_code_d = 2'd2;
            end else begin
              state_d    = ST_EOP;
              err_code_d = (bit_cnt_q != 3'd0) ? 2'd2 : err_code_q;
            end
          end else begin
            prev_nxt_s = line_j_s;
            if (ones_cnt_q == STUFF_LEN_C) begin
              if (!dec_s) begin
                // Stuffed zero: drop it without shifting.
                ones_cnt_d = 3'd0;
              end else if (is_hs_s) begin
                // HS EOP is a deliberate stuff violation; the partial byte is dropped.
                state_d   = ST_WAIT_IDLE;
                pkt_end_d = 1'b1;
                pkt_err_d = 1'b0;
              end else begin
                state_d    = ST_WAIT_IDLE;
                pkt_end_d  = 1'b1;
                pkt_err_d  = 1'b1;
                err_code_d = 2'd1;
              end
            end else begin
              sreg_d     = sreg_shift_s;
              ones_cnt_d = dec_s ? (ones_cnt_q + 3'd1) : 3'd0;
              bit_cnt_d  = bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                byte_data_d  = sreg_shift_s;
                byte_valid_d = 1'b1;
              end else begin
                byte_valid_d = 1'b0;
              end
            end
          end
        end

        ST_EOP: begin
          if (line_se0_s) begin
            state_d = ST_EOP;
          end else if (line_j_s) begin
            state_d   = ST_IDLE;
            pkt_end_d = 1'b1;
            pkt_err_d = (err_code_q != 2'd0);
          end else begin
            state_d    = ST_WAIT_IDLE;
            pkt_end_d  = 1'b1;
            pkt_err_d  = 1'b1;
            err_code_d = 2'd2;
          end
        end

        ST_WAIT_IDLE: begin
          if (is_hs_s ? line_se0_s : line_j_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // NRZI reference is preset to J whenever the FSM (re)enters IDLE.
    prev_d = (state_d == ST_IDLE) ? 1'b1 : prev_nxt_s;

    if (!rx_en) begin
      rx_active_d = 1'b0;
    end else if (pkt_start_d) begin
      rx_active_d = 1'b1;
    end else if (pkt_end_q) begin
      rx_active_d = 1'b0;
    end else begin
      rx_active_d = rx_active_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      speed_q      <= 2'd0;
      prev_q       <= 1'b1;
      zero_cnt_q   <= 5'd0;
      bit_cnt_q    <= 3'd0;
      ones_cnt_q   <= 3'd0;
      sreg_q       <= 8'd0;
      byte_data_q  <= 8'd0;
      byte_valid_q <= 1'b0;
      pkt_start_q  <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      err_code_q   <= 2'd0;
      rx_active_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      speed_q      <= speed_d;
      prev_q       <= prev_d;
      zero_cnt_q   <= zero_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      sreg_q       <= sreg_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      pkt_start_q  <= pkt_start_d;
      pkt_end_q    <= pkt_end_d;
      pkt_err_q    <= pkt_err_d;
      err_code_q   <= err_code_d;
      rx_active_q  <= rx_active_d;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign pkt_start  = pkt_start_q;
  assign pkt_end    = pkt_end_q;
  assign pkt_err    = pkt_err_q;
  assign err_code   = err_code_q;
  assign rx_active  = rx_active_q;

endmodule
